mdu_sequencer: RTL and testbench

- Multi-cycle unsigned multiply/divide unit for the MIPS32 core. Implements MULTU and DIVU and produces HI/LO.
- Reuses one alu_32bit instance as its only adder/subtractor, one ALU operation per cycle, using shift-add multiply and restoring divide.
- Sits beside the main ALU in EX. The pipeline issues with start and polls busy/done.

---
 rtl/mdu_sequencer_pkg.sv | 21 ++
 rtl/mdu_sequencer_alu.sv | 43 ++++
 rtl/mdu_sequencer.sv | 137 +++++++++++++
 tb/tb_mdu_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer:
// ALU select codes, FSM states and op encodings.
package mdu_sequencer_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_t;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage

// File: rtl/mdu_sequencer_alu.sv
// Datapath helpers for the MDU: the shared 32-bit ALU
// and the MSB-based carry/no-borrow reconstruction.
module alu_32bit
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    unique case (sel)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

module alu_carry32 (
  input  logic a_msb,
  input  logic b_msb,
  input  logic r_msb,
  output logic carry
);

  // b_msb is the effective operand (inverted for SUB),
  // so carry doubles as the no-borrow flag.
  assign carry = (a_msb & b_msb)
               | ((a_msb | b_msb) & ~r_msb);

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU unit built around a
// single shared ALU, one add/sub per cycle.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;

  logic             is_div;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] alu_r;
  logic [2:0]       alu_sel;
  logic             carry;
  logic             alu_zero_unused;
  logic             last;

  assign is_div  = (state == DIV);
  assign rem     = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign alu_a   = is_div ? rem : hi;
  assign alu_sel = is_div ? ALU_SUB : ALU_ADD;
  assign b_eff   = is_div ? ~opnd : opnd;
  assign last    = (cnt == CW'(ITER - 1));

  alu_32bit #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (opnd),
    .sel    (alu_sel),
    .result (alu_r),
    .zero   (alu_zero_unused)
  );

  alu_carry32 u_carry (
    .a_msb (alu_a[WIDTH-1]),
    .b_msb (b_eff[WIDTH-1]),
    .r_msb (alu_r[WIDTH-1]),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      opnd        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (op == OP_MULTU) begin
              opnd  <= rs_data;
              hi    <= '0;
              lo    <= rt_data;
              busy  <= 1'b1;
              state <= MUL;
            end else if (rt_data != '0) begin
              opnd  <= rt_data;
              hi    <= '0;
              lo    <= rs_data;
              busy  <= 1'b1;
              state <= DIV;
            end else begin
              hi          <= rs_data;
              lo          <= '1;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= FIN;
            end
          end
        end
        MUL: begin
          if (lo[0]) begin
            {hi, lo} <= {carry, alu_r, lo[WIDTH-1:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        DIV: begin
          // hi[MSB] is the 33rd remainder bit: always fits.
          if (hi[WIDTH-1] | carry) begin
            hi <= alu_r;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= rem;
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and random checks of mdu_sequencer against a
// 64-bit reference model through a result scoreboard.
module tb_mdu_sequencer;
  import mdu_sequencer_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] rs_data = '0;
  logic [W-1:0] rt_data = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  exp_t sb[$];

  mdu_sequencer #(.WIDTH(W), .ITER(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    e.dbz = 1'b0;
    if (o == OP_MULTU) begin
      p    = {32'b0, a} * {32'b0, b};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Leaves the bench in cycle N+1 of an op accepted at edge N.
  task automatic go(input logic o,
                    input logic [W-1:0] a,
                    input logic [W-1:0] b);
    step();
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    sb.push_back(model(o, a, b));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int exp_lat,
                           input int lat0);
    int   lat;
    exp_t e;
    lat = lat0;
    while (done !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".hi"}, hi, e.hi);
      chk({tag, ".lo"}, lo, e.lo);
      chk({tag, ".dbz"}, {31'b0, div_by_zero},
          {31'b0, e.dbz});
    end
  endtask

  task automatic run(input string tag,
                     input logic o,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b);
    go(o, a, b);
    wait_done(tag, (o && b == '0) ? 1 : 33, 1);
  endtask

  initial begin
    int b0;
    int d0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] edges [4];

    repeat (3) step();
    chk("rst.busy", {31'b0, busy}, 0);
    chk("rst.done", {31'b0, done}, 0);
    chk("rst.dbz", {31'b0, div_by_zero}, 0);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    rst_n = 1'b1;
    step();

    b0 = busy_cnt;
    run("mul3x5", OP_MULTU, 3, 5);
    chk("mul3x5.busy_cycles", busy_cnt - b0, 32);

    run("mul_ffxff", OP_MULTU, '1, '1);
    run("div100_7", OP_DIVU, 100, 7);
    run("div_ff_1", OP_DIVU, '1, 1);
    run("div_top", OP_DIVU, 32'h8000_0000, '1);

    b0 = busy_cnt;
    run("div_zero", OP_DIVU, 1234, 0);
    step();
    chk("div_zero.busy_cycles", busy_cnt - b0, 0);
    run("mul2x2", OP_MULTU, 2, 2);
    repeat (4) step();
    chk("hold.lo", lo, 4);
    chk("hold.hi", hi, 0);

    d0 = done_cnt;
    go(OP_MULTU, 6, 7);
    repeat (9) step();
    start   = 1'b1;
    op      = OP_DIVU;
    rs_data = 99;
    rt_data = 3;
    step();
    start = 1'b0;
    wait_done("ignored", 33, 11);
    repeat (4) step();
    chk("ignored.done_pulses", done_cnt - d0, 1);

    go(OP_DIVU, 1000, 3);
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'b0, busy}, 0);
    chk("abort.done", {31'b0, done}, 0);
    chk("abort.dbz", {31'b0, div_by_zero}, 0);
    chk("abort.hi", hi, 0);
    chk("abort.lo", lo, 0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("abort.no_done", done_cnt - d0, 0);
    run("after_abort", OP_DIVU, 1000, 3);

    edges[0] = 32'h8000_0000;
    edges[1] = 32'h7FFF_FFFF;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h0000_0001;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) begin
        run("edge_mul", OP_MULTU, edges[i], edges[j]);
        run("edge_div", OP_DIVU, edges[j], edges[i]);
      end
    end

    for (int i = 0; i < 160; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 3) rb = rb >> $urandom_range(31, 16);
      if (i % 40 == 5) rb = '0;
      run("rand", logic'(i % 2), ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
